// File: rtl/nfa_chain_engine.sv
// Linear-chain NFA matcher: one state flop per pattern position, class-gated,
// optional self-loops, with match counter and first-match offset capture.
module nfa_chain_engine #(
  parameter int                          N_STATES  = 28,
  parameter int                          N_CLASSES = 20,
  parameter int                          CLASS_W   = 5,
  parameter logic [N_STATES*CLASS_W-1:0] CLASS_SEL = '0,
  parameter logic [N_STATES-1:0]         LOOP_MASK = '0,
  parameter bit                          ANCHORED  = 1'b0,
  parameter int                          CNT_W     = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic                 sod,
  input  logic [N_CLASSES-1:0] cls_in,
  output logic                 match,
  output logic                 match_sticky,
  output logic [CNT_W-1:0]     match_cnt,
  output logic [CNT_W-1:0]     first_off,
  output logic                 first_vld
);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
  endfunction

  logic [N_STATES-1:0] s_q;
  logic [N_STATES-1:0] s_nxt;
  logic [N_STATES-1:0] prev;
  logic [N_STATES-1:0] c;
  logic [CNT_W-1:0]    byte_cnt;
  logic [CNT_W-1:0]    byte_idx;
  logic [CNT_W-1:0]    cnt_base;
  logic                armed_q;
  logic                start;
  logic                hit;
  logic                vld_base;
  logic                sticky_base;

  // Class lines; an out-of-range class index never matches, so that position is dead.
  always_comb begin
    c = '0;
    for (int i = 0; i < N_STATES; i++) begin
      for (int j = 0; j < N_CLASSES; j++) begin
        if (int'(CLASS_SEL[i*CLASS_W +: CLASS_W]) == j) c[i] = cls_in[j];
      end
    end
  end

  // A sod byte is evaluated against a cleared history.
  always_comb begin
    start       = ANCHORED ? (armed_q | sod) : 1'b1;
    prev        = sod ? '0 : s_q;
    byte_idx    = sod ? '0 : byte_cnt;
    cnt_base    = sod ? '0 : match_cnt;
    vld_base    = sod ? 1'b0 : first_vld;
    sticky_base = sod ? 1'b0 : match_sticky;
    s_nxt       = '0;
    s_nxt[0]    = c[0] & (start | (LOOP_MASK[0] & prev[0]));
    for (int i = 1; i < N_STATES; i++) begin
      s_nxt[i] = c[i] & (prev[i-1] | (LOOP_MASK[i] & prev[i]));
    end
    hit = en & s_nxt[N_STATES-1];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s_q          <= '0;
      armed_q      <= 1'b0;
      byte_cnt     <= '0;
      match_cnt    <= '0;
      match_sticky <= 1'b0;
      first_off    <= '0;
      first_vld    <= 1'b0;
    end else begin
      if (en) begin
        s_q      <= s_nxt;
        byte_cnt <= sat_inc(byte_idx);
        armed_q  <= 1'b0;
      end else if (sod) begin
        s_q      <= '0;
        byte_cnt <= '0;
        armed_q  <= 1'b1;
      end
      if (en || sod) begin
        match_cnt    <= hit ? sat_inc(cnt_base) : cnt_base;
        match_sticky <= sticky_base | hit;
        // first_off keeps its old value across sod; first_vld says whether it is current.
        if (hit && !vld_base) begin
          first_off <= byte_idx;
          first_vld <= 1'b1;
        end else begin
          first_vld <= vld_base;
        end
      end
    end
  end

  assign match = s_q[N_STATES-1];

endmodule
